// File: rtl/avalon_pio_ctrl_pkg.sv
// Shared constants for the Avalon-MM PIO port: register addresses and edge-capture modes.
package pio_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO port (HPS lightweight bridge side).
interface avalon_pio_ctrl_if;
  import pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/avalon_pio_ctrl_input_sync.sv
// Input synchroniser chain plus one-cycle history flop and edge detector for the PIO inputs.
module pio_input_sync
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] sync_q,
  output logic [DATA_WIDTH-1:0] edge_det
);

  logic [DATA_WIDTH-1:0] chain [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev_q <= '0;
    end else begin
      chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev_q <= sync_q;
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~sync_q & prev_q;
      EDGE_ANY:  edge_det = sync_q ^ prev_q;
      default:   edge_det = sync_q & ~prev_q;
    endcase
  end

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Avalon-MM general-purpose I/O port: direction control, atomic set/clear,
// synchronised readback, edge capture and a maskable level interrupt.
module avalon_pio_ctrl
  import pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    EDGE_TYPE   = EDGE_RISE,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_ctrl_if.slave      bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] dir_out,
  output logic                  irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(SYNC_STAGES + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic                  unused_wd;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic [DATA_WIDTH-1:0] edge_set;
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [CNT_W-1:0]      prime_cnt;
  logic                  primed;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  pio_input_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync_q  (sync_q),
    .edge_det(edge_det)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
      dir_out  <= '0;
      irq_mask <= '0;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA:    out_port <= wd;
        ADDR_DIR:     dir_out  <= wd;
        ADDR_IRQMASK: irq_mask <= wd;
        ADDR_OUTSET:  out_port <= out_port | wd;
        ADDR_OUTCLR:  out_port <= out_port & ~wd;
        default:      ;
      endcase
    end
  end

  // The synchroniser leaves reset holding zeros, so its first transitions are not real edges.
  assign primed = (prime_cnt == PRIME_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + CNT_W'(1);
  end

  // A new edge overrides a same-cycle write-1-clear so no event is lost.
  assign edge_clr = (wr_en && bus.address == ADDR_EDGE) ? wd : '0;
  assign edge_set = primed ? edge_det : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~edge_clr) | edge_set;
  end

  assign irq     = |(edge_capture & irq_mask);
  assign data_rd = (out_port & dir_out) | (sync_q & ~dir_out);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = BUS_W'(data_rd);
      ADDR_DIR:     bus.readdata = BUS_W'(dir_out);
      ADDR_IRQMASK: bus.readdata = BUS_W'(irq_mask);
      ADDR_EDGE:    bus.readdata = BUS_W'(edge_capture);
      default:      bus.readdata = '0;
    endcase
  end

endmodule
